// File: rtl/uart_rx_param.sv
// UART receiver with a 16x oversampling tick input. Data width, parity and stop length are parameters.
// Each frame reports its data together with a parity flag and a framing flag.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int   NW  = (DBIT > 8) ? 4 : 3;
    localparam logic PEN = (PARITY_EN != 0);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_next;
    logic [4:0]      s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            p, p_next;
    logic            perr, perr_next;
    logic            done_next, parity_err_next, frame_err_next;
    logic            rx_meta, rx_s, rx_p;

    // The synchroniser idles high, so a line that is already low at reset release
    // looks like a falling edge only after it has first returned high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain shifts by one stage per clock.
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_p    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            perr         <= 1'b0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            p            <= p_next;
            perr         <= perr_next;
            rx_done_tick <= done_next;
            parity_err   <= parity_err_next;
            frame_err    <= frame_err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise a missed branch would infer a latch.
        state_next      = state;
        s_next          = s;
        n_next          = n;
        b_next          = b;
        p_next          = p;
        perr_next       = perr;
        done_next       = 1'b0;
        parity_err_next = parity_err;
        frame_err_next  = frame_err;
        case (state)
            IDLE: begin
                if (rx_p && !rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 5'd7) begin
                        // Line back high at mid-start is a glitch, not a frame.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                            p_next     = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 5'd15) begin
                        b_next = {rx_s, b[DBIT-1:1]};
                        p_next = p ^ rx_s;
                        s_next = '0;
                        if (n == NW'(DBIT - 1)) begin
                            state_next = PEN ? PARITY : STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == 5'd15) begin
                        perr_next  = p ^ rx_s ^ ODD;
                        state_next = STOP;
                        s_next     = '0;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == 5'(SB_TICK - 1)) begin
                        done_next       = 1'b1;
                        frame_err_next  = ~rx_s;
                        parity_err_next = perr;
                        state_next      = IDLE;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout = b;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O with two stop bits) driven by
// a shared tick; every completed frame is compared against expectations queued by the sender.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int DIV = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic [6:0] dout_c;
    logic       done_a, done_b, done_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt[3] = '{0, 0, 0};
    int sent_cnt[3] = '{0, 0, 0};
    logic [2:0] prev_done = 3'b000;

    typedef struct {
        logic [8:0] dout;
        logic       perr;
        logic       ferr;
        int         fall_cyc;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       pbit;
        logic       stop_low;
        int         hold;
        logic [8:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    uart_rx_param #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a), .dout(dout_a),
        .rx_done_tick(done_a), .parity_err(perr_a), .frame_err(ferr_a));
    uart_rx_param #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b), .dout(dout_b),
        .rx_done_tick(done_b), .parity_err(perr_b), .frame_err(ferr_b));
    uart_rx_param #(.DBIT(7), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_c), .dout(dout_c),
        .rx_done_tick(done_c), .parity_err(perr_c), .frame_err(ferr_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : tick_gen
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            s_tick = (k == DIV - 1);
            k = (k + 1) % DIV;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "timeout");
    end

    function automatic int dbit_of(input int i);  return (i == 2) ? 7 : 8;  endfunction
    function automatic int pen_of(input int i);   return (i == 0) ? 0 : 1;  endfunction
    function automatic int odd_of(input int i);   return (i == 2) ? 1 : 0;  endfunction
    function automatic int sb_of(input int i);    return (i == 2) ? 32 : 16; endfunction
    function automatic int ticks_of(input int i);
        return 8 + 16 * (dbit_of(i) + pen_of(i)) + sb_of(i);
    endfunction

    // Reference: the word masked to its width; parity error when data ones plus the parity bit miss the configured sense.
    function automatic exp_t model(input int inst, input logic [8:0] data, input logic pbit, input logic stop_low);
        exp_t e;
        logic [8:0] m;
        m = data & ((9'd1 << dbit_of(inst)) - 9'd1);
        e.dout = m;
        e.perr = (pen_of(inst) != 0) ? ((($countones(m) + int'(pbit)) % 2) != odd_of(inst)) : 1'b0;
        e.ferr = stop_low;
        e.fall_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
        if (k > 0) #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                              input logic stop_low, input int hold, input exp_t e);
        e.fall_cyc = cyc;
        case (inst)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        sent_cnt[inst]++;
        set_line(inst, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < dbit_of(inst); i++) begin
            set_line(inst, data[i]);
            wait_ticks(16);
        end
        if (pen_of(inst) != 0) begin
            set_line(inst, pbit);
            wait_ticks(16);
        end
        set_line(inst, !stop_low);
        wait_ticks(sb_of(inst) + hold);
        set_line(inst, 1'b1);
        wait_ticks(1);
    endtask

    task automatic mon(input int inst, input logic done, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        int   pend, lat, lo, hi;
        if (done !== 1'b1) return;
        done_cnt[inst]++;
        check($sformatf("done_width[%0d]", inst), 32'(prev_done[inst]), 32'd0);
        case (inst)
            0: pend = q_a.size();
            1: pend = q_b.size();
            default: pend = q_c.size();
        endcase
        checks++;
        if (pend == 0) begin
            errors++;
            $display("FAIL unexpected_done[%0d]: actual done pulse required none", inst);
            return;
        end
        case (inst)
            0: e = q_a.pop_front();
            1: e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        check($sformatf("dout[%0d]", inst), 32'(d), 32'(e.dout));
        check($sformatf("parity_err[%0d]", inst), 32'(pe), 32'(e.perr));
        check($sformatf("frame_err[%0d]", inst), 32'(fe), 32'(e.ferr));
        lat = cyc - e.fall_cyc;
        lo  = DIV * ticks_of(inst) + DIV - 2;
        hi  = DIV * ticks_of(inst) + DIV + 1;
        checks++;
        if (lat < lo || lat > hi) begin
            errors++;
            $display("FAIL latency[%0d]: actual %0d clks required %0d..%0d", inst, lat, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, done_a, {1'b0, dout_a}, perr_a, ferr_a);
            mon(1, done_b, {1'b0, dout_b}, perr_b, ferr_b);
            mon(2, done_c, {2'b00, dout_c}, perr_c, ferr_c);
        end
        prev_done = {done_c, done_b, done_a};
    end

    initial begin : main
        vec_t vecs[8];
        int   n0;
        logic [7:0] c3;
        vecs[0] = '{0, 9'h055, 1'b0, 1'b0, 0,  9'h055, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h0FF, 1'b0, 1'b0, 0,  9'h0FF, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h0A5, 1'b0, 1'b0, 0,  9'h0A5, 1'b0, 1'b0};
        vecs[3] = '{1, 9'h0A5, 1'b1, 1'b0, 0,  9'h0A5, 1'b1, 1'b0};
        vecs[4] = '{2, 9'h05A, 1'b1, 1'b0, 0,  9'h05A, 1'b0, 1'b0};
        vecs[5] = '{2, 9'h05A, 1'b0, 1'b0, 0,  9'h05A, 1'b1, 1'b0};
        vecs[6] = '{0, 9'h03C, 1'b0, 1'b1, 48, 9'h03C, 1'b0, 1'b1};
        vecs[7] = '{0, 9'h012, 1'b0, 1'b0, 0,  9'h012, 1'b0, 1'b0};

        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_dout_a", 32'(dout_a), 32'd0);
        check("reset_done_a", 32'(done_a), 32'd0);
        check("reset_parity_err_a", 32'(perr_a), 32'd0);
        check("reset_frame_err_a", 32'(ferr_a), 32'd0);
        check("reset_dout_c", 32'(dout_c), 32'd0);
        reset = 1'b1;
        wait_ticks(4);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.dout = vecs[i].exp_dout;
            e.perr = vecs[i].exp_perr;
            e.ferr = vecs[i].exp_ferr;
            e.fall_cyc = 0;
            n0 = done_cnt[vecs[i].inst];
            send_frame(vecs[i].inst, vecs[i].data, vecs[i].pbit, vecs[i].stop_low, vecs[i].hold, e);
            check($sformatf("one_done_vec%0d", i), 32'(done_cnt[vecs[i].inst]), 32'(n0 + 1));
        end

        // Short low pulse on an idle line must be rejected at mid-start.
        n0 = done_cnt[0];
        set_line(0, 1'b0);
        wait_ticks(3);
        set_line(0, 1'b1);
        wait_ticks(20);
        check("glitch_no_done", 32'(done_cnt[0]), 32'(n0));
        send_frame(0, 9'h081, 1'b0, 1'b0, 0, exp_t'{9'h081, 1'b0, 1'b0, 0});
        send_frame(0, 9'h07E, 1'b0, 1'b1, 0, exp_t'{9'h07E, 1'b0, 1'b1, 0});

        // Reset in the middle of data bit 4 of 0xC3.
        n0 = done_cnt[0];
        c3 = 8'hC3;
        set_line(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            set_line(0, c3[i]);
            wait_ticks(16);
        end
        set_line(0, c3[4]);
        wait_ticks(8);
        reset = 1'b0;
        #1;
        check("midreset_dout_a", 32'(dout_a), 32'd0);
        check("midreset_done_a", 32'(done_a), 32'd0);
        check("midreset_parity_err_a", 32'(perr_a), 32'd0);
        check("midreset_frame_err_a", 32'(ferr_a), 32'd0);
        set_line(0, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        wait_ticks(40);
        check("midreset_no_done", 32'(done_cnt[0]), 32'(n0));
        check("midreset_frame_err_hold", 32'(ferr_a), 32'd0);
        send_frame(0, 9'h099, 1'b0, 1'b0, 0, exp_t'{9'h099, 1'b0, 1'b0, 0});

        for (int inst = 0; inst < 3; inst++) begin
            for (int f = 0; f < 8; f++) begin
                logic [8:0] data;
                logic       pbit, stop_low;
                data     = 9'($urandom);
                pbit     = 1'($urandom_range(0, 1));
                stop_low = ($urandom_range(0, 7) == 0);
                send_frame(inst, data, pbit, stop_low, 0, model(inst, data, pbit, stop_low));
                wait_ticks(int'($urandom_range(0, 4)));
            end
        end

        wait_ticks(8);
        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        check("pending_c", 32'(q_c.size()), 32'd0);
        for (int i = 0; i < 3; i++)
            check($sformatf("done_count[%0d]", i), 32'(done_cnt[i]), 32'(sent_cnt[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
